// File: rtl/dff_const_pkg.sv
// Shared encodings and expected-waveform presets for checking the dff_const family.
package dff_const_pkg;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_HOLD   = 2'd1;
  localparam logic [1:0] PH_TRANS  = 2'd2;
  localparam logic [1:0] PH_STEADY = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = PH_IDLE,
    S_HOLD   = PH_HOLD,
    S_TRANS  = PH_TRANS,
    S_STEADY = PH_STEADY
  } phase_e;

  typedef struct packed {
    logic       rst_val;
    logic       trans_val;
    logic [3:0] trans_cycles;
    logic       steady_val;
  } exp_cfg_t;

  // Expected q waveform for each dff_const variant after its reset is released.
  localparam exp_cfg_t DC1_EXP = '{rst_val: 1'b0, trans_val: 1'b0, trans_cycles: 4'd0, steady_val: 1'b0};
  localparam exp_cfg_t DC2_EXP = '{rst_val: 1'b1, trans_val: 1'b1, trans_cycles: 4'd0, steady_val: 1'b1};
  localparam exp_cfg_t DC3_EXP = '{rst_val: 1'b1, trans_val: 1'b0, trans_cycles: 4'd1, steady_val: 1'b1};
  localparam exp_cfg_t DC4_EXP = '{rst_val: 1'b0, trans_val: 1'b1, trans_cycles: 4'd1, steady_val: 1'b0};
  localparam exp_cfg_t DC5_EXP = '{rst_val: 1'b1, trans_val: 1'b0, trans_cycles: 4'd2, steady_val: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr and reset both return it to zero.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/dff_const_resp_checker.sv
// Watches a DUT reset and output q, checks q against a reset/transient/steady
// waveform and keeps sticky pass/fail plus error and release statistics.
module dff_const_resp_checker
  import dff_const_pkg::*;
#(
  parameter logic RST_VAL      = 1'b1,
  parameter logic TRANS_VAL    = 1'b0,
  parameter int   TRANS_CYCLES = 1,
  parameter logic STEADY_VAL   = 1'b1,
  parameter int   ERR_W        = 8,
  parameter int   REL_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             q_obs,
  output logic [1:0]       phase,
  output logic [ERR_W-1:0] err_count,
  output logic             fail,
  output logic             steady_ok,
  output logic [REL_W-1:0] rel_count
);

  localparam int TW = (TRANS_CYCLES > 0) ? $clog2(TRANS_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TC_LAST = (TRANS_CYCLES > 0) ? TW'(TRANS_CYCLES - 1) : '0;

  phase_e        r_phase;
  phase_e        w_phase_nxt;
  logic          r_fail;
  logic          r_steady_ok;
  logic          w_check;
  logic          w_exp;
  logic          w_rel;
  logic          w_trans_inc;
  logic          w_mismatch;
  logic          w_fail_nxt;
  logic [TW-1:0] w_trans_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= S_IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Samples that enter HOLD and the release sample are never checked:
  // they absorb the DUT's own register latency.
  always_comb begin
    w_phase_nxt = r_phase;
    w_check     = 1'b0;
    w_exp       = STEADY_VAL;
    w_rel       = 1'b0;
    w_trans_inc = 1'b0;
    case (r_phase)
      S_IDLE: begin
        if (dut_reset) w_phase_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (dut_reset) begin
          w_check = 1'b1;
          w_exp   = RST_VAL;
        end else begin
          w_rel       = 1'b1;
          w_phase_nxt = (TRANS_CYCLES > 0) ? S_TRANS : S_STEADY;
        end
      end
      S_TRANS: begin
        if (dut_reset) begin
          w_phase_nxt = S_HOLD;
        end else begin
          w_check     = 1'b1;
          w_exp       = TRANS_VAL;
          w_trans_inc = 1'b1;
          if (w_trans_cnt == TC_LAST) w_phase_nxt = S_STEADY;
        end
      end
      S_STEADY: begin
        if (dut_reset) begin
          w_phase_nxt = S_HOLD;
        end else begin
          w_check = 1'b1;
          w_exp   = STEADY_VAL;
        end
      end
      default: w_phase_nxt = S_IDLE;
    endcase
  end

  // Case inequality so an X or Z on q_obs is a mismatch in simulation.
  assign w_mismatch = w_check && (q_obs !== w_exp);
  assign w_fail_nxt = r_fail || w_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fail      <= 1'b0;
      r_steady_ok <= 1'b0;
    end else begin
      r_fail      <= w_fail_nxt;
      r_steady_ok <= (w_phase_nxt == S_STEADY) && !w_fail_nxt;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_mismatch),
    .count (err_count)
  );

  sat_counter #(.W(REL_W)) u_rel_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (w_rel),
    .count (rel_count)
  );

  sat_counter #(.W(TW)) u_trans_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_rel),
    .inc   (w_trans_inc),
    .count (w_trans_cnt)
  );

  assign phase     = r_phase;
  assign fail      = r_fail;
  assign steady_ok = r_steady_ok;

endmodule

// File: doc/dff_const_resp_checker.md
Name: dff_const_resp_checker

Overview:
- Synthesizable response checker; the observing end of the constant-flop reset/clock stimulus used with the dff_const family.
- Samples a DUT reset and a DUT output `q` every clock. Compares `q` against a parameterized expected waveform: reset value, then a post-release transient, then a steady value.
- Accumulates error and reset-release statistics for waveform-free pass/fail in simulation or on an FPGA harness.

Parameters:
- RST_VAL, 1'b1, expected `q` while DUT reset is held.
- TRANS_VAL, 1'b0, expected `q` during the post-release transient.
- TRANS_CYCLES, 1, number of checked transient samples (0 means no transient phase).
- STEADY_VAL, 1'b1, expected `q` after the transient.
- ERR_W, 8, width of the error counter.
- REL_W, 8, width of the release counter.

Ports:
- clk  input  1  checker clock, same clock as the DUT.
- reset  input  1  checker reset; synchronous, active-high.
- dut_reset  input  1  DUT reset as driven to the DUT.
- q_obs  input  1  DUT output under check.
- phase  output  2  current phase: 0 IDLE, 1 HOLD, 2 TRANS, 3 STEADY.
- err_count  output  ERR_W  mismatches since checker reset; saturates at all-ones.
- fail  output  1  sticky; set on the first mismatch.
- steady_ok  output  1  high while in STEADY and fail==0.
- rel_count  output  REL_W  completed DUT reset releases (1→0 samples); saturates.

Behaviour:
- Sampling: all inputs are sampled on the rising edge of `clk`. Outputs are registered, so updates are visible one cycle after the triggering sample.
- Checker reset (`reset` sampled 1):
  - phase=IDLE, err_count=0, fail=0, steady_ok=0, rel_count=0, internal transient counter=0.
  - `reset` overrides all other events in the same cycle.
- Settle rule: the first sample of HOLD, and the first sample after leaving HOLD, are not checked. This absorbs DUT output pipelining.
- FSM transitions, evaluated on each sample:
  - IDLE: dut_reset=1 → HOLD (settle sample). dut_reset=0 → remain IDLE, no checks.
  - HOLD, dut_reset=1: check q_obs==RST_VAL (except the settle sample); remain HOLD.
  - HOLD, dut_reset=0: release sample, unchecked. rel_count++; trans counter=0. Go to TRANS if TRANS_CYCLES>0, else STEADY.
  - TRANS, dut_reset=0: check q_obs==TRANS_VAL; trans counter++. When trans counter reaches TRANS_CYCLES → STEADY.
  - STEADY, dut_reset=0: check q_obs==STEADY_VAL.
  - TRANS or STEADY, dut_reset=1 (re-assert mid-operation): → HOLD. This sample is the HOLD settle sample, unchecked; no error for the aborted transient.
- Mismatch handling:
  - err_count += 1, saturating at 2^ERR_W-1 (no wrap).
  - fail set and held until checker reset.
  - The phase transition still occurs normally.
- steady_ok = (phase==STEADY) && !fail, registered.
- rel_count saturates at 2^REL_W-1.
- X/Z on q_obs in a checked sample counts as a mismatch (simulation: use case-inequality).
- dut_reset toggling every cycle: each 1 sample enters or stays in HOLD unchecked; no spurious errors are permitted.

Decomposition:
- Shared package `dff_const_pkg`:
  - phase encoding localparams: PH_IDLE=2'd0, PH_HOLD=2'd1, PH_TRANS=2'd2, PH_STEADY=2'd3.
  - default expected-value constants for dff_const1..5.
- One sub-module, `sat_counter`:
  - parameter W; ports clk, reset, clr, inc, count.
  - Instantiated twice (errors, releases).
  - Also sized internally for the transient counter as $clog2(TRANS_CYCLES+1), minimum 1 bit.

Test Plan:
- Defaults; reset=1 for 2 cycles, then dut_reset=1 for 5 cycles with q_obs=1, release, q_obs=1,0,1,1,1... → phase HOLD→TRANS→STEADY, steady_ok=1, err_count=0, rel_count=1.
- Defaults; q_obs=1 during the transient sample (expected 0) → err_count=1, fail=1, steady_ok=0 thereafter even in STEADY.
- Defaults; dut_reset reasserted on the transient sample → phase HOLD next cycle, err_count=0; second release completes → rel_count=2.
- ERR_W=2; q_obs stuck 0 in STEADY for 10 cycles → err_count saturates at 3, fail=1.
- TRANS_CYCLES=0, STEADY_VAL=0, RST_VAL=0 (dff_const1-style); q_obs=0 throughout → HOLD→STEADY directly, steady_ok=1, no errors.
- Checker `reset` asserted in STEADY with fail=1 and concurrent mismatch → all outputs cleared next cycle, phase=IDLE, err_count=0.
